// File: rtl/shift_add_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : shift_add_multiplier
// Description : Sequential unsigned shift-and-add multiplier feeding HiLo (MULTU).
// Revision    : 1.0
// ============================================================================
module shift_add_multiplier #(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [WIDTH-1:0]     dataA,
   input  logic [WIDTH-1:0]     dataB,
   output logic                 busy,
   output logic                 done,
   output logic                 hilo_we,
   output logic [2*WIDTH-1:0]   MulAns
);

   localparam int                CNT_W    = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t               state_q,   state_d;
   logic [2*WIDTH-1:0]   mcand_q,   mcand_d;
   logic [2*WIDTH-1:0]   acc_q,     acc_d;
   logic [2*WIDTH-1:0]   mul_ans_q, mul_ans_d;
   logic [WIDTH-1:0]     mplier_q,  mplier_d;
   logic [CNT_W-1:0]     cnt_q,     cnt_d;
   logic                 done_q,    done_d;
   logic                 hilo_we_q, hilo_we_d;
   logic [2*WIDTH-1:0]   acc_sum;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         mcand_q   <= '0;
         acc_q     <= '0;
         mul_ans_q <= '0;
         mplier_q  <= '0;
         cnt_q     <= '0;
         done_q    <= 1'b0;
         hilo_we_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         mcand_q   <= mcand_d;
         acc_q     <= acc_d;
         mul_ans_q <= mul_ans_d;
         mplier_q  <= mplier_d;
         cnt_q     <= cnt_d;
         done_q    <= done_d;
         hilo_we_q <= hilo_we_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      mcand_d   = mcand_q;
      acc_d     = acc_q;
      mul_ans_d = mul_ans_q;
      mplier_d  = mplier_q;
      cnt_d     = cnt_q;
      acc_sum   = acc_q + (mplier_q[0] ? mcand_q : '0);

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               mcand_d  = {{WIDTH{1'b0}}, dataA};
               mplier_d = dataB;
               acc_d    = '0;
               cnt_d    = '0;
               state_d  = ST_RUN;
            end
         end
         ST_RUN: begin
            acc_d    = acc_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            // Final partial product goes straight to MulAns on the DONE entry edge.
            if (cnt_q == LAST_CNT) begin
               state_d   = ST_DONE;
               mul_ans_d = acc_sum;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      done_d    = (state_d == ST_DONE);
      hilo_we_d = (state_d == ST_DONE);
   end

   assign busy    = (state_q != ST_IDLE);
   assign done    = done_q;
   assign hilo_we = hilo_we_q;
   assign MulAns  = mul_ans_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_add_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_add_multiplier
// Description : Scoreboard bench for shift_add_multiplier with a cycle-level model.
// Revision    : 1.0
// ============================================================================
module tb_shift_add_multiplier;

   localparam int W = 32;

   logic            clk    = 1'b0;
   logic            reset  = 1'b0;
   logic            start  = 1'b0;
   logic [W-1:0]    dataA  = '0;
   logic [W-1:0]    dataB  = '0;
   logic            busy;
   logic            done;
   logic            hilo_we;
   logic [2*W-1:0]  MulAns;

   int              n_cmp = 0;
   int              n_bad = 0;
   logic [2*W-1:0]  exp_q[$];
   logic [2*W-1:0]  exp_hold = '0;
   int              model_cnt = 0;

   shift_add_multiplier #(.WIDTH(W)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .dataA   (dataA),
      .dataB   (dataB),
      .busy    (busy),
      .done    (done),
      .hilo_we (hilo_we),
      .MulAns  (MulAns)
   );

   always #5 clk = ~clk;

   function automatic logic [2*W-1:0] mul_ref(input logic [W-1:0] a, input logic [W-1:0] b);
      return (2*W)'(a) * (2*W)'(b);
   endfunction

   task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, expv);
      end
   endtask

   // Model: an accepted request keeps the unit busy for W+1 cycles; the last of those is the done cycle.
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         model_cnt = 0;
         exp_q.delete();
      end else if (model_cnt > 0) begin
         model_cnt = model_cnt - 1;
      end else if (start) begin
         exp_q.push_back(mul_ref(dataA, dataB));
         model_cnt = W + 1;
      end
   end

   always @(negedge clk) begin
      logic [2*W-1:0] e;
      if (!reset) exp_hold = '0;
      chk("busy",    {63'd0, busy},    {63'd0, (model_cnt != 0)});
      chk("done",    {63'd0, done},    {63'd0, (model_cnt == 1)});
      chk("hilo_we", {63'd0, hilo_we}, {63'd0, (model_cnt == 1)});
      if (done || model_cnt == 1) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL product at %0t: got %0h, expected no completion", $time, MulAns);
         end else begin
            e = exp_q.pop_front();
            chk("product", MulAns, e);
            exp_hold = e;
         end
      end else begin
         chk("hold", MulAns, exp_hold);
      end
   end

   task automatic wait_idle();
      int g = 0;
      while (model_cnt != 0 && g < 200) begin
         @(negedge clk);
         g++;
      end
      if (g >= 200) begin
         n_cmp++;
         n_bad++;
         $display("FAIL idle_timeout at %0t: busy %0d, expected 0", $time, busy);
      end
   endtask

   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
      wait_idle();
      dataA = a;
      dataB = b;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      dataA = $urandom;
      dataB = $urandom;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog at %0t: got no finish, expected finish", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] a, b;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      issue(32'd3, 32'd5);
      issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
      issue(32'd0, 32'h1234);

      // Second start mid-run must be ignored.
      issue(32'd6000, 32'd7);
      repeat (9) @(negedge clk);
      start = 1'b1;
      dataA = 32'd9;
      dataB = 32'd9;
      @(negedge clk);
      start = 1'b0;

      // Reset during RUN discards the operation.
      issue(32'h1_0000, 32'h1_0000);
      repeat (14) @(posedge clk);
      #2 reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      issue(32'd2, 32'd2);

      // Start held high: repeated accepts back to back.
      wait_idle();
      dataA = 32'd7;
      dataB = 32'd11;
      start = 1'b1;
      repeat (3 * 34 + 2) @(negedge clk);
      start = 1'b0;

      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 5))
            0:       a = '0;
            1:       a = '1;
            default: a = $urandom;
         endcase
         case ($urandom_range(0, 5))
            0:       b = '0;
            1:       b = '1;
            default: b = $urandom;
         endcase
         issue(a, b);
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 25)) @(negedge clk);
            start = 1'b1;
            dataA = $urandom;
            dataB = $urandom;
            @(negedge clk);
            start = 1'b0;
         end
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      wait_idle();
      @(negedge clk);
      chk("queue_empty", (2*W)'(exp_q.size()), '0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
